// File: rtl/pb_event_decoder.sv
// Push-button gesture classifier: turns a debounced button level into
// short-press, long-press and double-click pulses plus a long-hold level.
module pb_event_decoder #(
  parameter int unsigned LONG_CNT = 50_000_000,
  parameter int unsigned GAP_CNT  = 25_000_000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic clk,
  input  logic resetn,
  input  logic pb_level,
  output logic short_tick,
  output logic long_tick,
  output logic double_tick,
  output logic hold,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    GAP       = 3'd2,
    PRESS2    = 3'd3,
    LONG_HOLD = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             short_n, long_n, double_n;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      short_tick  <= 1'b0;
      long_tick   <= 1'b0;
      double_tick <= 1'b0;
      hold        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      short_tick  <= short_n;
      long_tick   <= long_n;
      double_tick <= double_n;
      // hold/busy are derived from the next state so they line up with it.
      hold        <= (state_n == LONG_HOLD);
      busy        <= (state_n != IDLE);
    end
  end

  // Counter is compared before incrementing; every terminal value leaves
  // the state, so cnt can never wrap.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    short_n  = 1'b0;
    long_n   = 1'b0;
    double_n = 1'b0;
    case (state)
      IDLE: begin
        if (pb_level) begin
          state_n = PRESS1;
          cnt_n   = '0;
        end
      end
      PRESS1: begin
        if (!pb_level) begin
          state_n = GAP;
          cnt_n   = '0;
        end else if (cnt == LONG_LAST) begin
          long_n  = 1'b1;
          state_n = LONG_HOLD;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      GAP: begin
        if (pb_level) begin
          state_n = PRESS2;
          cnt_n   = '0;
        end else if (cnt == GAP_LAST) begin
          short_n = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      PRESS2: begin
        if (!pb_level) begin
          double_n = 1'b1;
          state_n  = IDLE;
        end else if (cnt == LONG_LAST) begin
          // A held second press wins: report it as long, drop the first press.
          long_n  = 1'b1;
          state_n = LONG_HOLD;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      LONG_HOLD: begin
        if (!pb_level) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pb_event_decoder.sv
// Directed bench for pb_event_decoder with LONG_CNT=8, GAP_CNT=5: each step
// drives one pb sample, then checks all outputs just after the edge.
module tb_pb_event_decoder;

  logic clk = 1'b0;
  logic resetn;
  logic pb_level;
  logic short_tick, long_tick, double_tick, hold, busy;

  int checks = 0;
  int errors = 0;

  pb_event_decoder #(.LONG_CNT(8), .GAP_CNT(5), .CNT_W(4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .pb_level    (pb_level),
    .short_tick  (short_tick),
    .long_tick   (long_tick),
    .double_tick (double_tick),
    .hold        (hold),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic es, input logic el,
                         input logic ed, input logic eh, input logic eb);
    chk({tag, " short"},  short_tick,  es);
    chk({tag, " long"},   long_tick,   el);
    chk({tag, " double"}, double_tick, ed);
    chk({tag, " hold"},   hold,        eh);
    chk({tag, " busy"},   busy,        eb);
  endtask

  // Drive a sample for the coming edge, then check just after it.
  task automatic step(input string tag, input int k, input logic lvl,
                      input logic es, input logic el, input logic ed,
                      input logic eh, input logic eb);
    pb_level = lvl;
    @(posedge clk);
    #1;
    chk_all($sformatf("%s k=%0d", tag, k), es, el, ed, eh, eb);
  endtask

  task automatic idle_steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, i, 1'b0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    resetn   = 1'b0;
    pb_level = 1'b0;
    #12;
    chk_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    resetn = 1'b1;
    idle_steps("idle", 2);

    // Short press: high 0..2, low from 3; short_tick after edge 8.
    for (int k = 0; k <= 10; k++)
      step("short", k, k <= 2, k == 8, 0, 0, 0, k <= 7);
    idle_steps("idle_a", 2);

    // Long press: high 0..20; long_tick after 8, hold 8..20.
    for (int k = 0; k <= 23; k++)
      step("long", k, k <= 20, 0, k == 8, 0, k >= 8 && k <= 20, k <= 20);
    idle_steps("idle_b", 2);

    // Double click: high 0-1, low 2-4, high 5-6, low 7.
    for (int k = 0; k <= 9; k++)
      step("double", k, k <= 1 || k == 5 || k == 6, 0, 0, k == 7, 0, k <= 6);
    idle_steps("idle_c", 2);

    // Gap boundary: timeout exactly at edge 6.
    for (int k = 0; k <= 8; k++)
      step("gap_to", k, k == 0, k == 6, 0, 0, 0, k <= 5);
    idle_steps("idle_d", 2);

    // Press at the timeout edge wins; release at 8 gives double_tick.
    for (int k = 0; k <= 10; k++)
      step("gap_press", k, k == 0 || k == 6 || k == 7, 0, 0, k == 8, 0, k <= 7);
    idle_steps("idle_e", 2);

    // Long second press: press 0, gap 1-2, held 3..15; long_tick after 11.
    for (int k = 0; k <= 18; k++)
      step("long2", k, k == 0 || (k >= 3 && k <= 15), 0, k == 11, 0,
           k >= 11 && k <= 15, k <= 15);
    idle_steps("idle_f", 2);

    // Reset mid-press, released with pb low: nothing follows.
    for (int k = 0; k <= 4; k++) step("rst_a", k, 1'b1, 0, 0, 0, 0, 1);
    resetn = 1'b0;
    #2;
    chk_all("rst_a async", 0, 0, 0, 0, 0);
    pb_level = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    idle_steps("rst_a after", 12);

    // Reset mid-press, released with pb high: fresh press, long after 8 edges.
    for (int k = 0; k <= 4; k++) step("rst_b", k, 1'b1, 0, 0, 0, 0, 1);
    resetn = 1'b0;
    #2;
    chk_all("rst_b async", 0, 0, 0, 0, 0);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k <= 10; k++)
      step("rst_b after", k, 1'b1, 0, k == 8, 0, k >= 8, 1);
    step("rst_b release", 0, 1'b0, 0, 0, 0, 0, 0);
    idle_steps("idle_g", 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
